// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes enter a circular FIFO over a valid/ready
// handshake and are serialised LSB first on a registered, idle-high line.
module uart_tx_fifo #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(BAUD_DIV);

  localparam logic [CW-1:0] CntReload = CW'(BAUD_DIV - 1);
  localparam logic [2:0]    LastStop  = 3'(STOP_BITS - 1);
  localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic          full, empty, push, pop;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  // Flags come from registered state only, so ready never depends on valid or a pop.
  assign full  = (level_q == LevelFull);
  assign empty = (level_q == '0);
  assign push  = tx_valid_i & ~full;

  assign tx_ready_o   = ~full;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != StIdle) | ~empty;
  assign fifo_level_o = level_q;

  // Storage is written only on an accepted push, so X on an unqualified bus never lands here.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr_q] <= tx_data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since the depth is a power of 2.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Frame state, baud counter, bit index, shifter and the line flop.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state: tx_d is the level of the bit being entered, so tx_o changes on the
  // same edge as the state and stays glitch-free.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rptr_q];
          cnt_d   = CntReload;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          cnt_d   = CntReload;
          bit_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          cnt_d = CntReload;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          cnt_d = CntReload;
          if (bit_q == LastStop) begin
            // Chain straight into the next start bit when more data is queued.
            if (!empty) begin
              pop     = 1'b1;
              shift_d = mem[rptr_q];
              state_d = StStart;
              tx_d    = 1'b0;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (1 and 2 stop bits), directed stimulus pushes
// expected bytes into per-unit queues; receiver monitors decode tx_o and check them.
module tb_uart_tx_fifo;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n    [2];
  logic [7:0] tx_data  [2];
  logic       tx_valid [2];
  logic       tx_ready [2];
  logic       tx       [2];
  logic       busy     [2];
  logic [2:0] lvl      [2];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut0 (
    .clk_i(clk), .arst_n_i(rst_n[0]), .tx_data_i(tx_data[0]), .tx_valid_i(tx_valid[0]),
    .tx_ready_o(tx_ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .fifo_level_o(lvl[0])
  );

  uart_tx_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut1 (
    .clk_i(clk), .arst_n_i(rst_n[1]), .tx_data_i(tx_data[1]), .tx_valid_i(tx_valid[1]),
    .tx_ready_o(tx_ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .fifo_level_o(lvl[1])
  );

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte until accepted; the expected frame is queued at the accepting edge.
  task automatic push(input int u, input logic [7:0] d);
    bit done = 1'b0;
    tx_valid[u] = 1'b1;
    tx_data[u]  = d;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (tx_ready[u]) begin
        @(posedge clk);
        #1;
        last_acc = cyc;
        done = 1'b1;
        if (u == 0) exp0.push_back(d);
        else        exp1.push_back(d);
      end else begin
        tick();
      end
    end
    tx_valid[u] = 1'b0;
    tx_data[u]  = 'x;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  // Strict receiver: every bit must hold for exactly BAUD samples; abandons on reset.
  task automatic rx_frame(input int u, input int stops, output logic [7:0] d,
                          output bit ok, output bit ab);
    ok = 1'b1;
    ab = 1'b0;
    d  = '0;
    for (int s = 0; s < 10 + stops - 1; s++) begin
      for (int i = 0; i < BAUD; i++) begin
        if (!(s == 0 && i == 0)) @(negedge clk);
        if (rst_n[u] !== 1'b1) begin
          ab = 1'b1;
          return;
        end
        if (s == 0) begin
          if (tx[u] !== 1'b0) ok = 1'b0;
        end else if (s <= 8) begin
          if (i == 0) d[s-1] = tx[u];
          else if (tx[u] !== d[s-1]) ok = 1'b0;
        end else begin
          if (tx[u] !== 1'b1) ok = 1'b0;
        end
      end
    end
  endtask

  task automatic score(input int u, input logic [7:0] d, input bit ok);
    logic [7:0] e;
    n_cmp++;
    if ((u == 0 ? exp0.size() : exp1.size()) == 0) begin
      n_err++;
      $display("FAIL rx%0d_unexpected: got frame %02h, want no frame", u, d);
    end else begin
      e = (u == 0) ? exp0.pop_front() : exp1.pop_front();
      if (!ok || d !== e) begin
        n_err++;
        $display("FAIL rx%0d_frame: got %02h framing_ok=%0d, want %02h framing_ok=1",
                 u, d, ok, e);
      end
    end
  endtask

  // Monitor for the one-stop-bit unit.
  initial begin : mon0
    logic [7:0] d;
    bit ok, ab;
    forever begin
      @(negedge clk);
      if (rst_n[0] === 1'b1 && tx[0] === 1'b0) begin
        rx_frame(0, 1, d, ok, ab);
        if (!ab) score(0, d, ok);
      end
    end
  end

  // Monitor for the two-stop-bit unit.
  initial begin : mon1
    logic [7:0] d;
    bit ok, ab;
    forever begin
      @(negedge clk);
      if (rst_n[1] === 1'b1 && tx[1] === 1'b0) begin
        rx_frame(1, 2, d, ok, ab);
        if (!ab) score(1, d, ok);
      end
    end
  end

  task automatic drain(input int u, input string name);
    int n = 0;
    while (((u == 0 ? exp0.size() : exp1.size()) != 0 || busy[u]) && n < 3000) begin
      tick();
      n++;
    end
    chk(name, (u == 0) ? exp0.size() : exp1.size(), 0);
  endtask

  // Abort a frame mid-DATA with two bytes queued, then send one fresh byte.
  task automatic reset_mid(input int u, input int stops);
    int k, n;
    push(u, 8'h3C);
    k = last_acc;
    push(u, 8'h5A);
    push(u, 8'h96);
    while (cyc != k + 6) tick();
    chk("t6_data_bit0", tx[u], 0);
    #1 rst_n[u] = 1'b0;
    #1;
    chk("t6_rst_tx", tx[u], 1);
    chk("t6_rst_level", lvl[u], 0);
    chk("t6_rst_busy", busy[u], 0);
    chk("t6_rst_ready", tx_ready[u], 1);
    if (u == 0) exp0.delete();
    else        exp1.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n[u] = 1'b1;
    tick();
    push(u, 8'h81);
    k = last_acc;
    n = 0;
    while (busy[u] && n < 1000) begin
      tick();
      n++;
    end
    chk("t6_frame_len", cyc - (k + 1), (10 + stops - 1) * BAUD);
    repeat (50) tick();
    chk("t6_leftover", (u == 0) ? exp0.size() : exp1.size(), 0);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got no finish, want finish before 1 ms");
    $fatal(1);
  end

  initial begin : stim
    int bad, k, n;
    logic [9:0] pat;
    rst_n    = '{1'b1, 1'b1};
    tx_valid = '{1'b0, 1'b0};
    tx_data  = '{8'h00, 8'h00};
    #2;
    rst_n = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_tx", tx[u], 1);
      chk("rst_ready", tx_ready[u], 1);
      chk("rst_busy", busy[u], 0);
      chk("rst_level", lvl[u], 0);
    end
    rst_n = '{1'b1, 1'b1};

    // 1: quiet line after reset release.
    bad = 0;
    repeat (1000) begin
      tick();
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || tx_ready[0] !== 1'b1 || lvl[0] !== 3'd0) bad++;
    end
    chk("t1_idle_1000", bad, 0);

    // 2: exact waveform of 0xA5 and busy fall time.
    push(0, 8'hA5);
    chk("t2_tx_at_k", tx[0], 1);
    pat = {1'b1, 8'hA5, 1'b0};
    for (int s = 0; s < 10; s++) begin
      bad = 0;
      for (int i = 0; i < BAUD; i++) begin
        tick();
        if (tx[0] !== pat[s]) bad++;
        if (busy[0] !== 1'b1) bad++;
      end
      chk($sformatf("t2_slot%0d", s), bad, 0);
    end
    tick();
    chk("t2_busy_fall", busy[0], 0);
    drain(0, "t2_drain");

    // 3: three back-to-back frames with no gap.
    push(0, 8'h00);
    k = last_acc;
    push(0, 8'hFF);
    push(0, 8'h55);
    n = 0;
    while (busy[0] && n < 1000) begin
      tick();
      n++;
    end
    chk("t3_frames_span", cyc - (k + 1), 30 * BAUD);
    drain(0, "t3_drain");

    // 4: producer held against a full FIFO.
    for (int i = 0; i < 10; i++) begin
      push(0, 8'(i * 37 + 9));
      if (i == 4) begin
        chk("t4_level_full", lvl[0], 4);
        chk("t4_ready_low", tx_ready[0], 0);
      end
    end
    drain(0, "t4_drain");

    // 5: push lands on the same edge as a pop at level 2.
    push(0, 8'h11);
    k = last_acc;
    push(0, 8'h22);
    push(0, 8'h33);
    while (cyc != k + 40) tick();
    chk("t5_level_before", lvl[0], 2);
    chk("t5_tx_stop", tx[0], 1);
    push(0, 8'h44);
    chk("t5_accept_edge", last_acc, k + 41);
    chk("t5_level_after", lvl[0], 2);
    chk("t5_next_start", tx[0], 0);
    drain(0, "t5_drain");

    // 6: asynchronous reset mid-frame, both stop-bit settings.
    reset_mid(0, 1);
    reset_mid(1, 2);

    chk("end_queue0", exp0.size(), 0);
    chk("end_queue1", exp1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
